// File: rtl/serial_digit_adder.sv
// Digit-serial adder: sum = a + b + cin, DIGIT_W bits per clock, LSB digit first.
// Latency: done pulses in the cycle after the NDIG-th RUN edge (NDIG+1 cycles after start is taken).
// Backpressure: start is taken only when ready=1 (IDLE or DONE); a start while busy is ignored.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, accepted on a clk edge when ready=1
//   a, b   - WIDTH-bit operands, sampled only on an accepted start
//   cin    - carry-in, sampled only on an accepted start
//   ready  - a start can be accepted this cycle
//   busy   - digit loop in progress (sum holds partial results)
//   done   - one-cycle pulse, sum/cout/ovf valid
//   sum    - result, stable from done until the next accepted start
//   cout   - carry out of bit WIDTH-1
//   ovf    - signed overflow (SIGNED=1) or unsigned carry-out (SIGNED=0)
module serial_digit_adder #(
   parameter int WIDTH   = 16,
   parameter int DIGIT_W = 4,
   parameter int SIGNED  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG  = WIDTH / DIGIT_W;
   // Keep the index at least one bit wide so NDIG==1 still elaborates.
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_carry;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;

   logic [DIGIT_W-1:0] w_da;
   logic [DIGIT_W-1:0] w_db;
   logic [DIGIT_W-1:0] w_dsum;
   logic               w_dcarry;
   logic               w_msb_cin;
   logic               w_last;

   // The single shared DIGIT_W-wide adder, fed by the digit selected by r_idx.
   always_comb begin
      w_da = r_a[r_idx*DIGIT_W +: DIGIT_W];
      w_db = r_b[r_idx*DIGIT_W +: DIGIT_W];
      {w_dcarry, w_dsum} = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT_W{1'b0}}, r_carry};
      // Carry into the top bit of the digit, recovered from that bit's sum:
      // s = a ^ b ^ c  =>  c = a ^ b ^ s. On the last digit this is the
      // carry into bit WIDTH-1, needed for two's-complement overflow.
      w_msb_cin = w_da[DIGIT_W-1] ^ w_db[DIGIT_W-1] ^ w_dsum[DIGIT_W-1];
      w_last    = (r_idx == IDX_W'(NDIG - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               // DONE lasts exactly one cycle, so done drops here either way.
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_idx   <= '0;
                  r_state <= S_RUN;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_RUN: begin
               r_sum[r_idx*DIGIT_W +: DIGIT_W] <= w_dsum;
               r_carry <= w_dcarry;
               r_idx   <= r_idx + 1'b1;
               if (w_last) begin
                  r_cout  <= w_dcarry;
                  r_ovf   <= (SIGNED != 0) ? (w_msb_cin ^ w_dcarry) : w_dcarry;
                  r_state <= S_DONE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign ready = r_ready;
   assign busy  = r_busy;
   assign done  = r_done;
   assign sum   = r_sum;
   assign cout  = r_cout;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: default (unsigned), SIGNED=1 and WIDTH=1 instances.
// Each op is checked for latency, busy length, result and done pulse width
// against an arithmetic model (a + b + cin, sign-rule overflow).
module tb_serial_digit_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // instance 0: WIDTH=16, DIGIT_W=4, SIGNED=0
   logic        start0, cin0, ready0, busy0, done0, cout0, ovf0;
   logic [15:0] a0, b0, sum0;
   // instance 1: WIDTH=16, DIGIT_W=4, SIGNED=1
   logic        start1, cin1, ready1, busy1, done1, cout1, ovf1;
   logic [15:0] a1, b1, sum1;
   // instance 2: WIDTH=1, DIGIT_W=1
   logic        start2, cin2, ready2, busy2, done2, cout2, ovf2;
   logic        a2, b2, sum2;

   serial_digit_adder #(.WIDTH(16), .DIGIT_W(4), .SIGNED(0)) u_dut_u (
      .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0),
      .ready(ready0), .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));

   serial_digit_adder #(.WIDTH(16), .DIGIT_W(4), .SIGNED(1)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

   serial_digit_adder #(.WIDTH(1), .DIGIT_W(1), .SIGNED(0)) u_dut_w1 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
      .ready(ready2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [15:0] a, input logic [15:0] b,
                        input logic ci);
      case (sel)
         0: begin start0 = st; a0 = a; b0 = b; cin0 = ci; end
         1: begin start1 = st; a1 = a; b1 = b; cin1 = ci; end
         default: begin start2 = st; a2 = a[0]; b2 = b[0]; cin2 = ci; end
      endcase
   endtask

   task automatic sample(input int sel, output logic rdy, output logic bsy, output logic dn,
                         output logic [15:0] s, output logic co, output logic ov);
      case (sel)
         0: begin rdy = ready0; bsy = busy0; dn = done0; s = sum0; co = cout0; ov = ovf0; end
         1: begin rdy = ready1; bsy = busy1; dn = done1; s = sum1; co = cout1; ov = ovf1; end
         default: begin rdy = ready2; bsy = busy2; dn = done2; s = {15'd0, sum2}; co = cout2; ov = ovf2; end
      endcase
   endtask

   // Reference: plain integer addition, overflow by the sign rule.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci, input int w,
                        input logic sgn, output logic [15:0] es, output logic ec, output logic eo);
      logic [16:0] msk;
      logic [16:0] full;
      msk  = (17'd1 << w) - 17'd1;
      full = ({1'b0, a} & msk) + ({1'b0, b} & msk) + {16'd0, ci};
      es   = full[15:0] & msk[15:0];
      ec   = full[w];
      if (sgn)
         eo = (a[w-1] == b[w-1]) && (es[w-1] != a[w-1]);
      else
         eo = ec;
   endtask

   // Wait (bounded) for done; returns cycles from the accepting edge and busy cycles seen.
   task automatic wait_done(input int sel, output int lat, output int nbusy);
      logic rdy, bsy, dn, co, ov;
      logic [15:0] s;
      lat = 0; nbusy = 0; dn = 1'b0;
      while (!dn && lat < 20) begin
         @(negedge clk);
         lat++;
         sample(sel, rdy, bsy, dn, s, co, ov);
         if (bsy) nbusy++;
      end
   endtask

   task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input int nd, input int w, input logic sgn, input string tag);
      logic [15:0] es, s;
      logic ec, eo, rdy, bsy, dn, co, ov;
      int lat, nb;
      model(a, b, ci, w, sgn, es, ec, eo);
      @(negedge clk);
      drive(sel, 1'b1, a, b, ci);
      @(posedge clk);
      #1;
      // scramble inputs after acceptance: must not affect the op in flight
      drive(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      wait_done(sel, lat, nb);
      sample(sel, rdy, bsy, dn, s, co, ov);
      check({tag, "_latency"}, lat, nd + 1);
      check({tag, "_busy_cycles"}, nb, nd);
      check({tag, "_ready_at_done"}, {31'd0, rdy}, 1);
      check({tag, "_sum"}, {16'd0, s}, {16'd0, es});
      check({tag, "_cout"}, {31'd0, co}, {31'd0, ec});
      check({tag, "_ovf"}, {31'd0, ov}, {31'd0, eo});
      @(negedge clk);
      sample(sel, rdy, bsy, dn, s, co, ov);
      check({tag, "_done_width"}, {31'd0, dn}, 0);
      check({tag, "_hold_sum"}, {16'd0, s}, {16'd0, es});
   endtask

   initial begin : main
      logic rdy, bsy, dn, co, ov;
      logic [15:0] s, es, ra, rb;
      logic ec, eo, rc;
      int lat, nb, seen;

      drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
      drive(1, 1'b0, 16'd0, 16'd0, 1'b0);
      drive(2, 1'b0, 16'd0, 16'd0, 1'b0);

      // reset held with start asserted
      rst_n = 1'b0;
      drive(0, 1'b1, 16'h1234, 16'h4321, 1'b1);
      repeat (3) @(negedge clk);
      sample(0, rdy, bsy, dn, s, co, ov);
      check("rst_sum", {16'd0, s}, 0);
      check("rst_cout", {31'd0, co}, 0);
      check("rst_ovf", {31'd0, ov}, 0);
      check("rst_done", {31'd0, dn}, 0);
      check("rst_ready", {31'd0, rdy}, 1);
      check("rst_busy", {31'd0, bsy}, 0);
      drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sample(0, rdy, bsy, dn, s, co, ov);
      check("post_rst_ready", {31'd0, rdy}, 1);
      check("post_rst_busy", {31'd0, bsy}, 0);

      // directed cases
      do_op(0, 16'h1234, 16'h4321, 1'b0, 4, 16, 1'b0, "basic");
      do_op(0, 16'hFFFF, 16'h0000, 1'b1, 4, 16, 1'b0, "ripple");
      do_op(1, 16'h7FFF, 16'h0001, 1'b0, 4, 16, 1'b1, "sgn_ovf");
      do_op(1, 16'hFFFF, 16'h0001, 1'b0, 4, 16, 1'b1, "sgn_wrap");
      do_op(1, 16'h8000, 16'hFFFF, 1'b0, 4, 16, 1'b1, "sgn_neg_ovf");

      // WIDTH=1 full-adder truth table
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         do_op(2, {15'd0, v[2]}, {15'd0, v[1]}, v[0], 1, 1, 1'b0, "w1");
      end

      // back-to-back: start held through RUN (ignored) and into DONE (accepted)
      @(negedge clk);
      drive(0, 1'b1, 16'h0F0F, 16'h1111, 1'b0);
      @(posedge clk);
      #1;
      drive(0, 1'b1, 16'hABCD, 16'h1357, 1'b1);
      wait_done(0, lat, nb);
      sample(0, rdy, bsy, dn, s, co, ov);
      check("b2b_first_latency", lat, 5);
      check("b2b_first_sum", {16'd0, s}, 32'h2020);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
      wait_done(0, lat, nb);
      sample(0, rdy, bsy, dn, s, co, ov);
      model(16'hABCD, 16'h1357, 1'b1, 16, 1'b0, es, ec, eo);
      check("b2b_gap", lat, 5);
      check("b2b_second_sum", {16'd0, s}, {16'd0, es});
      check("b2b_second_cout", {31'd0, co}, {31'd0, ec});
      @(negedge clk);
      sample(0, rdy, bsy, dn, s, co, ov);
      check("b2b_done_width", {31'd0, dn}, 0);

      // reset during RUN cycle 2 aborts the op
      @(negedge clk);
      drive(0, 1'b1, 16'h8888, 16'h9999, 1'b1);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      sample(0, rdy, bsy, dn, s, co, ov);
      check("abort_sum", {16'd0, s}, 0);
      check("abort_cout", {31'd0, co}, 0);
      check("abort_ovf", {31'd0, ov}, 0);
      check("abort_ready", {31'd0, rdy}, 1);
      check("abort_busy", {31'd0, bsy}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         sample(0, rdy, bsy, dn, s, co, ov);
         if (dn || bsy) seen++;
      end
      check("abort_no_done", seen, 0);

      // randomized ops
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         do_op(0, ra, rb, rc, 4, 16, 1'b0, "rnd_u");
      end
      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         do_op(1, ra, rb, rc, 4, 16, 1'b1, "rnd_s");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
